dpram_arbiter: RTL and testbench
================================

// Module: dpram_arbiter
// PURPOSE
//  Shares one port of the 16-bit-word / byte-addressed dual-port RAM between two requesters:
//  port 1 = J1 core, port 2 = peripheral core. Runs a round-robin, one-transaction-at-a-time
//  req/ack handshake, drives the RAM strobes/address/data, and returns read data per requester.
//  Out-of-range word addresses are rejected with an error ack and never reach the RAM.
// PARAMETERS
//  RAM_BYTES  32  RAM size in bytes; a word access touches bytes addr and addr+1
//  RAM_LAT    1   posedges from strobe cycle to ram_dout capture; must be >= 1
// PORTS
//  clk        in   1   system clock; all logic on posedge
//  rst        in   1   synchronous, active-high reset
//  p1_req     in   1   J1 request; held high until p1_ack
//  p1_we      in   1   1 = write, 0 = read; sampled at grant
//  p1_addr    in   8   byte address of low byte; sampled at grant
//  p1_wdata   in   16  write data, [7:0] -> addr, [15:8] -> addr+1; sampled at grant
//  p1_rdata   out  16  read data; valid with p1_ack on a read, held until the next p1 read
//  p1_ack     out  1   one-cycle completion pulse
//  p1_err     out  1   high with p1_ack when addr > RAM_BYTES-2
//  p2_req, p2_we, p2_addr, p2_wdata, p2_rdata, p2_ack, p2_err: as p1_*, peripheral side
//  ram_rd     out  1   RAM read strobe, one cycle
//  ram_wr     out  1   RAM write strobe, one cycle
//  ram_addr   out  8   RAM byte address
//  ram_din    out  16  RAM write data
//  ram_dout   in   16  RAM read data
//  gnt        out  2   one-hot owner of current transaction ({p2,p1}); 00 when idle
//  busy       out  1   high whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, including p*_rdata; last_grant=p2, so p1 wins the first tie.
//  FSM: IDLE -> ACCESS -> WAIT -> DONE -> IDLE.
//   IDLE: if exactly one req, grant it. If both req, grant the one not equal to last_grant.
//     At grant: latch we/addr/wdata, set gnt, set last_grant. Addr check (addr > RAM_BYTES-2):
//     fail -> go directly to DONE with err=1 and no strobe; pass -> go to ACCESS.
//   ACCESS (1 cycle): ram_addr/ram_din drive the latched values. Assert ram_wr if we=1, else
//     ram_rd. Strobes are never both high and are high only in ACCESS.
//     ram_addr/ram_din stay stable from ACCESS through DONE.
//   WAIT: down-counter, RAM_LAT-1 cycles; skipped when RAM_LAT=1. On the transition into DONE,
//     a read captures ram_dout into the owner's rdata. The other requester's rdata is untouched.
//   DONE (1 cycle): pulse owner's ack (and err if flagged); next state IDLE; gnt cleared on exit.
//  Latency, req first seen high in IDLE cycle 0:
//   strobe in cycle 1; ack in cycle 1+RAM_LAT (cycle 2 for default); error ack in cycle 1.
//   Back-to-back: the next arbitration occurs in the IDLE cycle following DONE. No new grant is
//   made in DONE.
//  Handshake: requester deasserts req in the cycle after ack; if req is still high in the
//   following IDLE cycle, it is a new transaction. Dropping req before ack does not abort the
//   transaction; it completes and acks anyway.
//  Fairness: under continuous dual requests, grants strictly alternate p1,p2,p1,... Error acks
//   update last_grant too.
//  Address arithmetic: addr+1 is the RAM's concern. Max legal addr = RAM_BYTES-2 (30 by default).
//  rst in any state: returns to IDLE in the next cycle with strobes, ack and err low. A pending
//   strobe is dropped, never held.
// TESTING
//  1 p1 write addr=4 wdata=16'hBEEF, then p1 read addr=4 -> ram_wr in cycle 1, ack cycle 2;
//    read ack carries p1_rdata=16'hBEEF.
//  2 p1 and p2 both request reads from reset, held continuously -> gnt sequence 01,10,01,10;
//    never two consecutive grants to one port.
//  3 p2 read addr=31 (and addr=8'hFF) -> p2_ack+p2_err in cycle 1; ram_rd/ram_wr stay 0;
//    p2_rdata unchanged; addr=30 accepted with err=0.
//  4 RAM_LAT=3 instance, p2 read -> ram_rd cycle 1, ack cycle 4, rdata equals ram_dout sampled
//    at the cycle-4 edge; p1_rdata unchanged.
//  5 rst pulsed high during ACCESS of a p1 write -> next cycle IDLE, gnt=00, no ack.
//    Afterwards simultaneous reqs grant p1 first.

Source files
------------

// File: rtl/dpram_arbiter.sv
// rtl/dpram_arbiter.sv - round-robin req/ack arbiter sharing one dual-port RAM port between J1 and peripheral
module dpram_arbiter #(
  parameter int RAM_BYTES = 32,
  parameter int RAM_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [7:0]  p1_addr,
  input  logic [15:0] p1_wdata,
  output logic [15:0] p1_rdata,
  output logic        p1_ack,
  output logic        p1_err,
  input  logic        p2_req,
  input  logic        p2_we,
  input  logic [7:0]  p2_addr,
  input  logic [15:0] p2_wdata,
  output logic [15:0] p2_rdata,
  output logic        p2_ack,
  output logic        p2_err,
  output logic        ram_rd,
  output logic        ram_wr,
  output logic [7:0]  ram_addr,
  output logic [15:0] ram_din,
  input  logic [15:0] ram_dout,
  output logic [1:0]  gnt,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  localparam int         CW       = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [7:0] MAX_ADDR = 8'(RAM_BYTES - 2);

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          last_p2_q, last_p2_d;
  logic          we_q, we_d;
  logic [7:0]    addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   rd1_q, rd1_d;
  logic [15:0]   rd2_q, rd2_d;

  logic          pick1, pick2, capture;
  logic [7:0]    sel_addr;

  // On a tie the port that did not win last time gets the grant.
  assign pick1    = p1_req & (~p2_req | last_p2_q);
  assign pick2    = p2_req & (~p1_req | ~last_p2_q);
  assign sel_addr = pick2 ? p2_addr : p1_addr;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_p2_d = last_p2_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick1 || pick2) begin
          gnt_d     = {pick2, pick1};
          last_p2_d = pick2;
          we_d      = pick2 ? p2_we : p1_we;
          addr_d    = sel_addr;
          wdata_d   = pick2 ? p2_wdata : p1_wdata;
          err_d     = sel_addr > MAX_ADDR;
          state_d   = (sel_addr > MAX_ADDR) ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (RAM_LAT > 1) begin
          cnt_d   = CW'(RAM_LAT - 2);
          state_d = S_WAIT;
        end else begin
          capture = ~we_q;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          capture = ~we_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        gnt_d   = 2'b00;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd1_d = rd1_q;
    rd2_d = rd2_q;
    if (capture && gnt_q[0]) rd1_d = ram_dout;
    if (capture && gnt_q[1]) rd2_d = ram_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= 2'b00;
      last_p2_q <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= 8'h00;
      wdata_q   <= 16'h0000;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      rd1_q     <= 16'h0000;
      rd2_q     <= 16'h0000;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_p2_q <= last_p2_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
    end
  end

  // Strobes decode from ACCESS only, so they can never overlap or linger.
  assign ram_rd   = (state_q == S_ACCESS) & ~we_q;
  assign ram_wr   = (state_q == S_ACCESS) & we_q;
  assign ram_addr = addr_q;
  assign ram_din  = wdata_q;
  assign p1_ack   = (state_q == S_DONE) & gnt_q[0];
  assign p2_ack   = (state_q == S_DONE) & gnt_q[1];
  assign p1_err   = p1_ack & err_q;
  assign p2_err   = p2_ack & err_q;
  assign p1_rdata = rd1_q;
  assign p2_rdata = rd2_q;
  assign gnt      = gnt_q;
  assign busy     = state_q != S_IDLE;

endmodule

// File: tb/tb_dpram_arbiter.sv
// tb/tb_dpram_arbiter.sv - randomized bench for dpram_arbiter against a transaction-level model
module tb_dpram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p1_req, p1_we, p2_req, p2_we;
  logic [7:0]  p1_addr, p2_addr;
  logic [15:0] p1_wdata, p2_wdata;
  logic [15:0] p1_rdata, p2_rdata;
  logic        p1_ack, p1_err, p2_ack, p2_err;
  logic        ram_rd, ram_wr;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din, ram_dout;
  logic [1:0]  gnt;
  logic        busy;

  logic        q1_req, q1_we, q2_req, q2_we;
  logic [7:0]  q1_addr, q2_addr;
  logic [15:0] q1_wdata, q2_wdata;
  logic [15:0] q1_rdata, q2_rdata;
  logic        q1_ack, q1_err, q2_ack, q2_err;
  logic        q_ram_rd, q_ram_wr;
  logic [7:0]  q_ram_addr;
  logic [15:0] q_ram_din, q_dout;
  logic [1:0]  q_gnt;
  logic        q_busy;

  logic [7:0]  ram_mem [32];
  logic [7:0]  ref_mem [32];
  logic [15:0] ref_rd1, ref_rd2;
  int          last_gnt;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  dpram_arbiter u_dut (
    .clk(clk), .rst(rst),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_ack(p1_ack), .p1_err(p1_err),
    .p2_req(p2_req), .p2_we(p2_we), .p2_addr(p2_addr), .p2_wdata(p2_wdata),
    .p2_rdata(p2_rdata), .p2_ack(p2_ack), .p2_err(p2_err),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .gnt(gnt), .busy(busy)
  );

  dpram_arbiter #(.RAM_BYTES(32), .RAM_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .p1_req(q1_req), .p1_we(q1_we), .p1_addr(q1_addr), .p1_wdata(q1_wdata),
    .p1_rdata(q1_rdata), .p1_ack(q1_ack), .p1_err(q1_err),
    .p2_req(q2_req), .p2_we(q2_we), .p2_addr(q2_addr), .p2_wdata(q2_wdata),
    .p2_rdata(q2_rdata), .p2_ack(q2_ack), .p2_err(q2_err),
    .ram_rd(q_ram_rd), .ram_wr(q_ram_wr), .ram_addr(q_ram_addr), .ram_din(q_ram_din),
    .ram_dout(q_dout), .gnt(q_gnt), .busy(q_busy)
  );

  // Bench RAM: writes on the strobe edge, read data combinational from the held address.
  assign ram_dout = {ram_mem[ram_addr[4:0] + 5'd1], ram_mem[ram_addr[4:0]]};
  always @(posedge clk) begin
    if (ram_wr) begin
      ram_mem[ram_addr[4:0]]        <= ram_din[7:0];
      ram_mem[ram_addr[4:0] + 5'd1] <= ram_din[15:8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic new_op(input int port, input bit rd_only);
    logic [7:0] a;
    a = ($urandom_range(9) == 0) ? 8'($urandom_range(255, 31)) : 8'($urandom_range(30));
    if (port == 1) begin
      p1_req = 1'b1; p1_we = rd_only ? 1'b0 : 1'($urandom_range(1));
      p1_addr = a; p1_wdata = 16'($urandom);
    end else begin
      p2_req = 1'b1; p2_we = rd_only ? 1'b0 : 1'($urandom_range(1));
      p2_addr = a; p2_wdata = 16'($urandom);
    end
  endtask

  // Runs one transaction from its arbitration cycle (cycle 0) to the ack; ends at the ack negedge.
  task automatic do_txn(output int w);
    bit          e, wr, got;
    logic [7:0]  a;
    logic [15:0] wd;
    int          sc, c;
    if (p1_req && p2_req) w = (last_gnt == 1) ? 2 : 1;
    else                  w = p1_req ? 1 : 2;
    last_gnt = w;
    wr = (w == 1) ? p1_we : p2_we;
    a  = (w == 1) ? p1_addr : p2_addr;
    wd = (w == 1) ? p1_wdata : p2_wdata;
    e  = a > 8'd30;
    sc = -1; c = 0; got = 1'b0;
    while (!got && c < 10) begin
      @(negedge clk);
      if (c == 0) chk("gnt_idle", 32'(gnt), 32'd0);
      if (c == 1) chk("gnt_owner", 32'(gnt), (w == 1) ? 32'd1 : 32'd2);
      if (ram_rd || ram_wr) begin
        if (sc >= 0) chk("strobe_once", 32'(c), 32'(sc));
        else sc = c;
        chk("strobe_kind", 32'({ram_wr, ram_rd}), wr ? 32'd2 : 32'd1);
        chk("ram_addr", 32'(ram_addr), 32'(a));
        if (wr) chk("ram_din", 32'(ram_din), 32'(wd));
      end
      if (p1_ack || p2_ack) begin
        got = 1'b1;
        chk("ack_cycle", 32'(c), e ? 32'd1 : 32'd2);
        chk("ack_port", 32'({p2_ack, p1_ack}), (w == 1) ? 32'd1 : 32'd2);
        chk("ack_err", 32'({p2_err, p1_err}), e ? ((w == 1) ? 32'd1 : 32'd2) : 32'd0);
        if (!e && wr) begin
          ref_mem[a[4:0]] = wd[7:0];
          ref_mem[a[4:0] + 5'd1] = wd[15:8];
        end
        if (!e && !wr) begin
          if (w == 1) ref_rd1 = {ref_mem[a[4:0] + 5'd1], ref_mem[a[4:0]]};
          else        ref_rd2 = {ref_mem[a[4:0] + 5'd1], ref_mem[a[4:0]]};
        end
        chk("p1_rdata", 32'(p1_rdata), 32'(ref_rd1));
        chk("p2_rdata", 32'(p2_rdata), 32'(ref_rd2));
      end else begin
        @(posedge clk); #1;
        c++;
      end
    end
    chk("ack_timeout", 32'(got), 32'd1);
    chk("strobe_cycle", 32'(sc), e ? 32'hFFFF_FFFF : 32'd1);
  endtask

  task automatic next_in(input int w, input bit cont);
    @(posedge clk); #1;
    if (w == 1) begin
      if (cont || $urandom_range(1) == 1) new_op(1, cont); else p1_req = 1'b0;
    end else begin
      if (cont || $urandom_range(1) == 1) new_op(2, cont); else p2_req = 1'b0;
    end
    if (!p1_req && !p2_req) begin
      case ($urandom_range(2))
        0:       new_op(1, 1'b0);
        1:       new_op(2, 1'b0);
        default: begin new_op(1, 1'b0); new_op(2, 1'b0); end
      endcase
    end
  endtask

  task automatic set_op(input int port, input bit we, input logic [7:0] a, input logic [15:0] wd);
    if (port == 1) begin p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = wd; end
    else           begin p2_req = 1'b1; p2_we = we; p2_addr = a; p2_wdata = wd; end
  endtask

  initial begin
    int w, c, sc;
    bit got;
    logic [15:0] hist;
    rst = 1'b1;
    {p1_req, p1_we, p1_addr, p1_wdata, p2_req, p2_we, p2_addr, p2_wdata} = '0;
    {q1_req, q1_we, q1_addr, q1_wdata, q2_req, q2_we, q2_addr, q2_wdata} = '0;
    q_dout = 16'h0;
    for (int i = 0; i < 32; i++) begin
      ram_mem[i] = 8'($urandom);
      ref_mem[i] = ram_mem[i];
    end
    ref_rd1 = 16'h0; ref_rd2 = 16'h0; last_gnt = 2;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_gnt_busy", 32'({gnt, busy}), 32'd0);
    chk("rst_acks", 32'({p1_ack, p1_err, p2_ack, p2_err, ram_rd, ram_wr}), 32'd0);
    chk("rst_rdata", 32'({p1_rdata, p2_rdata}), 32'd0);
    chk("rst_ram_bus", 32'({ram_addr, ram_din}), 32'd0);
    chk("rst_lat3", 32'({q_gnt, q_busy, q1_rdata}), 32'd0);

    // Continuous dual reads from reset alternate p1,p2,p1,p2.
    new_op(1, 1'b1); new_op(2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      do_txn(w);
      chk("alt_grant", 32'(w), (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i < 3) next_in(w, 1'b1);
    end

    @(posedge clk); #1;
    p2_req = 1'b0;
    set_op(1, 1'b1, 8'd4, 16'hBEEF);
    do_txn(w);
    @(posedge clk); #1;
    set_op(1, 1'b0, 8'd4, 16'h0);
    do_txn(w);
    chk("rd_beef", 32'(p1_rdata), 32'h0000_BEEF);

    @(posedge clk); #1;
    p1_req = 1'b0;
    set_op(2, 1'b0, 8'd31, 16'h0);
    do_txn(w);
    @(posedge clk); #1;
    set_op(2, 1'b0, 8'hFF, 16'h0);
    do_txn(w);
    @(posedge clk); #1;
    set_op(2, 1'b0, 8'd30, 16'h0);
    do_txn(w);
    @(posedge clk); #1;
    p2_req = 1'b0;

    // RAM_LAT=3 instance: strobe in cycle 1, ack in cycle 4 with the data present at that edge.
    q2_req = 1'b1; q2_addr = 8'd6;
    c = 0; got = 1'b0; sc = -1; hist = q_dout;
    while (!got && c < 10) begin
      @(negedge clk);
      if (q_ram_rd && sc < 0) sc = c;
      if (q2_ack) begin
        got = 1'b1;
        chk("lat3_ack_cycle", 32'(c), 32'd4);
        chk("lat3_rdata", 32'(q2_rdata), 32'(hist));
        chk("lat3_p1_rdata", 32'(q1_rdata), 32'd0);
      end else begin
        hist = q_dout;
        @(posedge clk); #1;
        q_dout = 16'($urandom);
        c++;
      end
    end
    chk("lat3_timeout", 32'(got), 32'd1);
    chk("lat3_strobe", 32'(sc), 32'd1);
    @(posedge clk); #1;
    q2_req = 1'b0;

    new_op(1, 1'b0);
    for (int i = 0; i < 150; i++) begin
      do_txn(w);
      next_in(w, 1'b0);
    end
    do_txn(w);
    @(posedge clk); #1;
    p1_req = 1'b0; p2_req = 1'b0;

    // Reset in the ACCESS cycle of a p1 write.
    @(posedge clk); #1;
    set_op(1, 1'b1, 8'd2, 16'h1234);
    @(posedge clk); #1;
    chk("rst_mid_wr", 32'(ram_wr), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; p1_req = 1'b0;
    chk("rst_mid_state", 32'({gnt, busy, ram_rd, ram_wr}), 32'd0);
    chk("rst_mid_ack", 32'({p1_ack, p1_err, p2_ack, p2_err}), 32'd0);
    chk("rst_mid_rdata", 32'({p1_rdata, p2_rdata}), 32'd0);
    ref_mem[2] = 8'h34; ref_mem[3] = 8'h12;
    ref_rd1 = 16'h0; ref_rd2 = 16'h0; last_gnt = 2;
    @(posedge clk); #1;
    new_op(1, 1'b1); new_op(2, 1'b1);
    do_txn(w);
    chk("rst_tie_p1", 32'(w), 32'd1);
    @(posedge clk); #1;
    p1_req = 1'b0; p2_req = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
